// File: rtl/scim_bank_counter_array_if.sv
// Bundle between the SCIM bank controller and the bank counter array:
// sense-amp bits, stage-aligned controls and published shadow results.
interface scim_bank_counter_array_if #(
   parameter int N_S = 32,
   parameter int N_C = 32,
   parameter int BCP = 7
);
   logic                     SA_LATCH;
   logic                     COMP_POSITIVE_PHASE;
   logic                     CTR_EN;
   logic                     CTR_CLR;
   logic                     CTR_LATCH;
   logic                     BUF_CLR;
   logic [N_S*N_C-1:0]       ET_TRIGG;
   logic [N_S*N_C-1:0]       CLP;
   logic [N_S*N_C-1:0]       CLN;
   logic [N_S*N_C*BCP-1:0]   BANK_CTR_LATCHED;
   logic                     LATCH_VALID;
   logic [N_S*N_C-1:0]       SAT_FLAG;

   // LATCH_VALID has no ready: it is a one-cycle pulse, the consumer must
   // take BANK_CTR_LATCHED in that cycle; the shadow then holds until the next latch.
   modport master (
      output SA_LATCH, COMP_POSITIVE_PHASE, CTR_EN, CTR_CLR, CTR_LATCH, BUF_CLR,
      output ET_TRIGG, CLP, CLN,
      input  BANK_CTR_LATCHED, LATCH_VALID, SAT_FLAG
   );

   modport slave (
      input  SA_LATCH, COMP_POSITIVE_PHASE, CTR_EN, CTR_CLR, CTR_LATCH, BUF_CLR,
      input  ET_TRIGG, CLP, CLN,
      output BANK_CTR_LATCHED, LATCH_VALID, SAT_FLAG
   );
endinterface

// File: rtl/scim_bank_counter_array.sv
// Three-stage SCIM bank counter: sense-amp capture, saturating signed up/down
// counters, shadow publish. Optional macro BANK_CTR_SHADOW_ACC_EN accumulates into the shadow.
module scim_bank_counter_array #(
   parameter int N_S = 32,
   parameter int N_C = 32,
   parameter int BCP = 7
) (
   input logic                     CLK,
   input logic                     RESET,
   scim_bank_counter_array_if.slave bus
);
   localparam int NT = N_S * N_C;
   localparam logic [BCP:0] DELTA_UP = {{BCP{1'b0}}, 1'b1};
   localparam logic [BCP:0] DELTA_DN = {(BCP+1){1'b1}};

   // Returns {clamped, value}: overflow of the BCP+1 bit sum shows as the two top bits differing.
   function automatic logic [BCP:0] sat_add(input logic [BCP:0] a, input logic [BCP:0] b);
      logic [BCP:0] s;
      s = a + b;
      if (s[BCP] != s[BCP-1])
         sat_add = {1'b1, s[BCP], {(BCP-1){~s[BCP]}}};
      else
         sat_add = {1'b0, s[BCP-1:0]};
   endfunction

   logic [NT-1:0] sa_p;
   logic [NT-1:0] sa_n;
   logic          latch_valid_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sa_p <= '0;
         sa_n <= '0;
      end else if (bus.SA_LATCH) begin
         sa_p <= bus.CLP;
         sa_n <= bus.CLN;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         latch_valid_q <= 1'b0;
      else
         latch_valid_q <= bus.CTR_LATCH & ~bus.BUF_CLR;
   end

   assign bus.LATCH_VALID = latch_valid_q;

   for (genvar k = 0; k < NT; k++) begin : g_ctr
      logic [BCP-1:0] ctr_q;
      logic [BCP-1:0] shadow_q;
      logic           sat_q;
      logic           inc;
      logic           dec;
      logic [BCP:0]   delta;
      logic [BCP:0]   cnt_sum;

      assign inc     = bus.COMP_POSITIVE_PHASE ? (sa_p[k] & ~sa_n[k]) : (~sa_p[k] & sa_n[k]);
      assign dec     = bus.COMP_POSITIVE_PHASE ? (~sa_p[k] & sa_n[k]) : (sa_p[k] & ~sa_n[k]);
      assign delta   = inc ? DELTA_UP : (dec ? DELTA_DN : '0);
      assign cnt_sum = sat_add({ctr_q[BCP-1], ctr_q}, delta);

`ifdef BANK_CTR_SHADOW_ACC_EN
      logic [BCP:0] acc_sum;
      assign acc_sum = sat_add({shadow_q[BCP-1], shadow_q}, {ctr_q[BCP-1], ctr_q});
`endif

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            ctr_q    <= '0;
            shadow_q <= '0;
            sat_q    <= 1'b0;
         end else begin
            if (bus.CTR_CLR) begin
               ctr_q <= '0;
               sat_q <= 1'b0;
            end else if (bus.CTR_EN && !bus.ET_TRIGG[k]) begin
               ctr_q <= cnt_sum[BCP-1:0];
               if (cnt_sum[BCP])
                  sat_q <= 1'b1;
            end
            // Shadow reads ctr_q as it stood before this edge, so latch+clear loses no count.
            if (bus.BUF_CLR) begin
               shadow_q <= '0;
            end else if (bus.CTR_LATCH) begin
`ifdef BANK_CTR_SHADOW_ACC_EN
               shadow_q <= acc_sum[BCP-1:0];
               if (acc_sum[BCP])
                  sat_q <= 1'b1;
`else
               shadow_q <= ctr_q;
`endif
            end
         end
      end

      assign bus.BANK_CTR_LATCHED[k*BCP +: BCP] = shadow_q;
      assign bus.SAT_FLAG[k]                    = sat_q;
   end
endmodule

// File: tb/tb_scim_bank_counter_array.sv
// Directed vector-table bench for scim_bank_counter_array (default 32x32x7);
// counter 5 is the probed counter, counter 6 plus both ends are its neighbours.
module tb_scim_bank_counter_array;
  localparam int NS = 32;
  localparam int NC = 32;
  localparam int B  = 7;
  localparam int NT = NS * NC;
  localparam int K  = 5;

  logic clk;
  logic rst;

  scim_bank_counter_array_if #(.N_S(NS), .N_C(NC), .BCP(B)) bus ();

  scim_bank_counter_array #(.N_S(NS), .N_C(NC), .BCP(B)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sa_latch;
    logic clp;
    logic cln;
    logic pos;
    logic en;
    logic clr;
    logic lat;
    logic bclr;
    logic et;
    int   reps;
    logic chk;
    int   exp5;
    int   exp6;
    logic sat;
    logic valid;
  } vec_t;

  vec_t vt[$];
  logic [B-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(input logic sl, cp, cn, ps, en, cl, lt, bc, et,
                              input int reps, input logic chk,
                              input int e5, e6, input logic s, v);
    vec_t r;
    r = '{sl, cp, cn, ps, en, cl, lt, bc, et, reps, chk, e5, e6, s, v};
    return r;
  endfunction

  function automatic int shadow_of(input int k);
    logic signed [B-1:0] s;
    s = bus.BANK_CTR_LATCHED[k*B +: B];
    return int'(s);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive_idle();
    bus.SA_LATCH = 1'b0; bus.COMP_POSITIVE_PHASE = 1'b1; bus.CTR_EN = 1'b0;
    bus.CTR_CLR = 1'b0; bus.CTR_LATCH = 1'b0; bus.BUF_CLR = 1'b0;
    bus.ET_TRIGG = '0; bus.CLP = '0; bus.CLN = '0;
  endtask

  // driver: hold one record for reps cycles, then compare
  task automatic apply(input int idx, input vec_t v);
    logic [B-1:0] e;
    for (int r = 0; r < v.reps; r++) begin
      bus.SA_LATCH = v.sa_latch;
      bus.CLP = {NT{v.clp}};
      bus.CLN = {NT{v.cln}};
      bus.COMP_POSITIVE_PHASE = v.pos;
      bus.CTR_EN = v.en;
      bus.CTR_CLR = v.clr;
      bus.CTR_LATCH = v.lat;
      bus.BUF_CLR = v.bclr;
      bus.ET_TRIGG = '0;
      bus.ET_TRIGG[K] = v.et;
      @(posedge clk);
      #1;
    end
    if (v.chk) begin
      exp_q.push_back(B'(v.exp5));
      e = exp_q.pop_front();
      check($sformatf("v%0d_shadow_k5", idx), shadow_of(K), int'($signed(e)));
      check($sformatf("v%0d_shadow_k6", idx), shadow_of(K+1), v.exp6);
      check($sformatf("v%0d_shadow_k0", idx), shadow_of(0), v.exp6);
      check($sformatf("v%0d_shadow_klast", idx), shadow_of(NT-1), v.exp6);
      check($sformatf("v%0d_sat_k5", idx), int'(bus.SAT_FLAG[K]), int'(v.sat));
      check($sformatf("v%0d_sat_k6", idx), int'(bus.SAT_FLAG[K+1]), int'(v.sat));
      check($sformatf("v%0d_latch_valid", idx), int'(bus.LATCH_VALID), int'(v.valid));
    end
  endtask

  initial begin
    // columns: sa_latch clp cln pos en clr lat bclr et | reps chk exp5 exp6 sat valid
`ifdef BANK_CTR_SHADOW_ACC_EN
    vt.push_back(mk(0,0,0,1,0,1,0,0,0,  1,0,  0,  0,0,0)); // clear
    vt.push_back(mk(1,1,0,1,0,0,0,0,0,  1,0,  0,  0,0,0)); // capture p-bits
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 20,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,1,1,0,0,  1,1, 20, 20,0,1)); // latch+clear window 1
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 30,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,1,1,0,0,  1,1, 50, 50,0,1)); // window 2
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 25,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,1,1,0,0,  1,1, 63, 63,1,1)); // window 3 clamps the sum
    vt.push_back(mk(0,1,0,1,0,0,0,1,0,  1,1,  0,  0,1,0)); // buf_clr starts a new sum
`else
    vt.push_back(mk(1,1,0,1,0,0,0,0,0,  1,0,  0,  0,0,0)); // capture p-bits
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 10,0,  0,  0,0,0)); // 10 up
    vt.push_back(mk(0,1,0,0,1,0,0,0,0,  4,0,  0,  0,0,0)); // 4 down (negative phase)
    vt.push_back(mk(0,1,0,0,0,0,1,0,0,  1,1,  6,  6,0,1));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0,  1,1,  6,  6,0,0)); // pulse drops, shadow holds
    vt.push_back(mk(1,1,1,1,0,0,0,0,0,  1,0,  0,  0,0,0)); // both bits set
    vt.push_back(mk(0,1,1,1,1,0,0,0,0,  5,0,  0,  0,0,0));
    vt.push_back(mk(0,1,1,1,0,0,1,0,0,  1,1,  6,  6,0,1));
    vt.push_back(mk(0,0,0,1,0,1,0,0,0,  1,0,  0,  0,0,0)); // saturation
    vt.push_back(mk(1,1,0,1,0,0,0,0,0,  1,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 70,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,1,0,0,  1,1, 63, 63,1,1));
    vt.push_back(mk(0,1,0,1,0,1,0,0,0,  1,1, 63, 63,0,0)); // clear drops flag only
    vt.push_back(mk(1,0,1,1,0,0,0,0,0,  1,0,  0,  0,0,0)); // n-bits
    vt.push_back(mk(0,0,1,1,1,0,0,0,0,140,0,  0,  0,0,0));
    vt.push_back(mk(0,0,1,1,0,0,1,0,0,  1,1,-64,-64,1,1));
    vt.push_back(mk(0,0,1,1,0,1,0,0,0,  1,1,-64,-64,0,0));
    vt.push_back(mk(1,1,0,1,0,0,0,0,0,  1,0,  0,  0,0,0)); // early termination
    vt.push_back(mk(0,1,0,1,1,0,0,0,0,  8,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,1,0,0,0,1, 20,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,1,0,1,  1,1,  8, 28,0,1));
    vt.push_back(mk(0,1,0,1,0,1,0,0,0,  1,0,  0,  0,0,0)); // simultaneous events
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 17,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,1,1,0,0,  1,1, 17, 17,0,1)); // pre-clear value latched
    vt.push_back(mk(0,1,0,1,0,0,1,0,0,  1,1,  0,  0,0,1)); // back-to-back pulse
    vt.push_back(mk(0,1,0,1,1,0,0,0,0,  5,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,1,1,0,  1,1,  0,  0,0,0)); // buf_clr wins
    vt.push_back(mk(0,1,0,1,0,0,1,0,0,  1,1,  5,  5,0,1));
`endif
    // common tail: load 12, then saturate before the mid-cycle reset
    vt.push_back(mk(0,1,0,1,0,1,0,0,0,  1,0,  0,  0,0,0));
    vt.push_back(mk(1,1,0,1,0,0,0,0,0,  1,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 12,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,1,0,0,  1,1, 12, 12,0,1));
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, 70,0,  0,  0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,1,0,0,  1,1, 63, 63,1,1));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bank_ones", $countones(bus.BANK_CTR_LATCHED), 0);
    check("reset_sat_ones", $countones(bus.SAT_FLAG), 0);
    check("reset_latch_valid", int'(bus.LATCH_VALID), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) apply(i, vt[i]);

    // asynchronous reset between edges while LATCH_VALID and SAT_FLAG are high
    #2;
    rst = 1'b1;
    #1;
    check("midreset_bank_ones", $countones(bus.BANK_CTR_LATCHED), 0);
    check("midreset_sat_ones", $countones(bus.SAT_FLAG), 0);
    check("midreset_latch_valid", int'(bus.LATCH_VALID), 0);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // captured bits were cleared, so enabling the counters adds nothing
    apply(100, mk(0,1,0,1,1,0,0,0,0, 3,0, 0, 0,0,0));
    apply(101, mk(0,1,0,1,0,0,1,0,0, 1,1, 0, 0,0,1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
